// File: rtl/sum_rizado_arb_pkg.sv
// Shared definitions for the sum_rizado_arb adder arbiter: datapath width,
// toggle counter width, FSM state encodings and a small popcount helper.
package sum_rizado_arb_pkg;

  localparam int SR_W        = 8;
  localparam int SR_TOGGLE_W = 16;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Number of set bits in a {co,s} result word
  function automatic logic [3:0] popcount9(input logic [SR_W:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i <= SR_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sum_rizado_arb_adder.sv
// SUM_RIZADO: plain 8-bit ripple-carry adder, one full adder per bit.
// Carry propagates bit by bit, which is why the arbiter holds the operands
// steady for a settle window before capturing the result.
module sum_rizado_arb_adder
  import sum_rizado_arb_pkg::*;
(
  input  logic [SR_W-1:0] a,
  input  logic [SR_W-1:0] b,
  input  logic            ci,
  output logic [SR_W-1:0] s,
  output logic            co
);

  logic [SR_W:0] c;

  // Ripple chain: each stage consumes the carry of the stage below it
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SR_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[SR_W];

endmodule

// File: rtl/sum_rizado_arb.sv
// sum_rizado_arb: round-robin sequencer sharing one ripple adder between N
// requesters. Operands are registered on grant, the adder is given a fixed
// settle window, and {co,s} is returned over a valid/ready response port.
// Non-last beats lock the arbiter to the same requester and chain the carry.
// Optional feature: define SUM_RIZADO_ARB_TOGGLE_EN to count result bit toggles.
module sum_rizado_arb
  import sum_rizado_arb_pkg::*;
#(
  parameter int N             = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDW           = 1
)
(
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [N-1:0]           req_valid,
  input  logic [SR_W*N-1:0]      req_a,
  input  logic [SR_W*N-1:0]      req_b,
  input  logic [N-1:0]           req_ci,
  input  logic [N-1:0]           req_last,
  output logic [N-1:0]           req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [SR_W-1:0]        rsp_s,
  output logic                   rsp_co,
  output logic                   busy,
  output logic [SR_TOGGLE_W-1:0] toggle_cnt
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [SR_W-1:0] a_reg;
  logic [SR_W-1:0] b_reg;
  logic            ci_reg;
  logic            last_reg;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  rr_ptr;
  logic            lock;
  logic            chain_c;

  logic [IDW:0]    pick_res;
  logic            found;
  logic [IDW-1:0]  sel;
  logic            grant;
  logic            settle_done;
  logic [SR_W-1:0] sum_s;
  logic            sum_co;

  // First valid requester at or above ptr, wrapping; MSB flags a hit
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] v, input logic [IDW-1:0] ptr);
    logic [IDW:0] r;
    int j;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (v[j]) r = {1'b1, IDW'(j)};
    end
    return r;
  endfunction

  // Choose the grant candidate: the locked requester during a chain, else round-robin
  always_comb begin
    pick_res = rr_pick(req_valid, rr_ptr);
    if (lock) begin
      found = req_valid[gid];
      sel   = gid;
    end else begin
      found = pick_res[IDW];
      sel   = pick_res[IDW-1:0];
    end
    grant = (state == IDLE) && reset_L && found;
  end

  assign req_ready   = grant ? (N'(1) << sel) : '0;
  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE) || lock;
  assign settle_done = (state == SETTLE) && (cnt == CW'(SETTLE_CYCLES - 1));

  sum_rizado_arb_adder u_adder (
    .a  (a_reg),
    .b  (b_reg),
    .ci (ci_reg),
    .s  (sum_s),
    .co (sum_co)
  );

  // Main sequencer: grant and register operands, settle, then hold the response
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      ci_reg   <= 1'b0;
      last_reg <= 1'b0;
      gid      <= '0;
      rr_ptr   <= '0;
      lock     <= 1'b0;
      chain_c  <= 1'b0;
      rsp_id   <= '0;
      rsp_s    <= '0;
      rsp_co   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            a_reg    <= req_a[sel*SR_W +: SR_W];
            b_reg    <= req_b[sel*SR_W +: SR_W];
            ci_reg   <= lock ? chain_c : req_ci[sel];
            last_reg <= req_last[sel];
            gid      <= sel;
            cnt      <= '0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            rsp_s  <= sum_s;
            rsp_co <= sum_co;
            rsp_id <= gid;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            if (last_reg) begin
              lock   <= 1'b0;
              rr_ptr <= (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
            end else begin
              lock    <= 1'b1;
              chain_c <= rsp_co;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUM_RIZADO_ARB_TOGGLE_EN
  localparam int TW = SR_TOGGLE_W + 1;

  logic [SR_W:0]        prev;
  logic [SR_TOGGLE_W-1:0] tog_reg;
  logic [TW-1:0]        tog_sum;

  // Candidate count including this capture's toggles, one bit wider to spot overflow
  always_comb begin
    tog_sum = {1'b0, tog_reg} + TW'(popcount9({sum_co, sum_s} ^ prev));
  end

  // Accumulate toggles at each capture, saturating at all-ones
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      prev    <= '0;
      tog_reg <= '0;
    end else if (settle_done) begin
      prev    <= {sum_co, sum_s};
      tog_reg <= tog_sum[SR_TOGGLE_W] ? {SR_TOGGLE_W{1'b1}} : tog_sum[SR_TOGGLE_W-1:0];
    end
  end

  assign toggle_cnt = tog_reg;
`else
  assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_sum_rizado_arb.sv
// Self-checking bench for sum_rizado_arb (N=2, SETTLE_CYCLES=2).
// Expected responses are queued when a grant is seen and compared by a
// monitor when the DUT presents the matching response.
module tb_sum_rizado_arb;

  logic        clk;
  logic        reset_L;
  logic [1:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  req_ci;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_s;
  logic        rsp_co;
  logic        busy;
  logic [15:0] toggle_cnt;

  int total = 0;
  int bad   = 0;

  // Entry layout: [10]=last, [9]=id, [8]=co, [7:0]=s
  logic [10:0] exp_q[$];
  logic [10:0] ent;
  logic        m_lock;
  logic        m_c;
  int          m_rr;

`ifdef SUM_RIZADO_ARB_TOGGLE_EN
  localparam logic [15:0] EXP_TOG = 16'd8;
`else
  localparam logic [15:0] EXP_TOG = 16'd0;
`endif

  sum_rizado_arb #(
    .N             (2),
    .SETTLE_CYCLES (2),
    .IDW           (1)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ci     (req_ci),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_co     (rsp_co),
    .busy       (busy),
    .toggle_cnt (toggle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: compare each response in the cycle it is accepted
  always @(negedge clk) begin
    if (reset_L && rsp_valid && rsp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL rsp_unexpected: got id=%0d co=%0d s=%h, expected no response",
                 rsp_id, rsp_co, rsp_s);
      end else begin
        ent = exp_q.pop_front();
        if ({rsp_id, rsp_co, rsp_s} !== ent[9:0]) begin
          bad++;
          $display("[TB] FAIL rsp_data: got id=%0d co=%0d s=%h, expected id=%0d co=%0d s=%h",
                   rsp_id, rsp_co, rsp_s, ent[9], ent[8], ent[7:0]);
        end
        if (ent[10]) begin
          m_lock = 1'b0;
          m_rr   = (int'(ent[9]) + 1) % 2;
        end else begin
          m_lock = 1'b1;
          m_c    = ent[8];
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_L   = 1'b0;
    req_valid = 2'b00;
    exp_q.delete();
    m_lock = 1'b0;
    m_c    = 1'b0;
    m_rr   = 0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one beat on requester r, wait for its grant, queue the expected result
  task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic last);
    logic       ce;
    logic [8:0] sum;
    bit         ok;
    @(posedge clk); #1;
    req_a[8*r +: 8] = a;
    req_b[8*r +: 8] = b;
    req_ci[r]       = ci;
    req_last[r]     = last;
    req_valid[r]    = 1'b1;
    ok = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[r] === 1'b1) ok = 1;
    end
    if (ok) begin
      ce  = m_lock ? m_c : ci;
      sum = {1'b0, a} + {1'b0, b} + {8'b0, ce};
      exp_q.push_back({last, r[0], sum});
      @(posedge clk); #1;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL issue_timeout: requester %0d got no ready, expected a grant", r);
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #2 reset_L = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if ({rsp_id, rsp_co, rsp_s} !== 10'h000) begin
      bad++; $display("[TB] FAIL reset_rsp_regs: got %h expected 000", {rsp_id, rsp_co, rsp_s});
    end
    total++;
    if (toggle_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL reset_toggle: got %h expected 0000", toggle_cnt); end
    req_valid = 2'b00;
    m_lock = 1'b0;
    m_c    = 1'b0;
    m_rr   = 0;
    reset_L = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat;
    bit got;
    req_a[7:0] = 8'h3C;
    req_b[7:0] = 8'h0F;
    req_ci[0]  = 1'b0;
    req_last[0] = 1'b1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_grant: got %b expected 01", req_ready); end
    exp_q.push_back({1'b1, 1'b0, 9'h04B});
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL single_ready_pulse: got %b expected 00", req_ready); end
    req_valid[0] = 1'b0;
    got = 0;
    lat = 1;
    while (lat < 20 && !got) begin
      if (rsp_valid === 1'b1) got = 1;
      else begin lat++; @(negedge clk); end
    end
    total++;
    if (!got || lat != 3) begin bad++; $display("[TB] FAIL single_latency: got %0d cycles expected 3", lat); end
    drain();
  endtask

  task automatic test_overflow();
    issue(0, 8'hFF, 8'h01, 1'b1, 1'b1);
    drain();
    issue(1, 8'h7F, 8'h80, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      issue(i % 2, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      drain();
    end
  endtask

  task automatic test_contention();
    int         grants;
    int         g;
    logic [1:0] exp_g;
    logic [8:0] sum;
    apply_reset();
    req_a = 16'h2010; req_b = 16'h0504; req_ci = 2'b01; req_last = 2'b11;
    req_valid = 2'b11;
    grants = 0;
    for (int k = 0; k < 200 && grants < 4; k++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        exp_g = (m_rr == 0) ? 2'b01 : 2'b10;
        total++;
        if (req_ready !== exp_g) begin
          bad++; $display("[TB] FAIL contention_grant%0d: got %b expected %b", grants, req_ready, exp_g);
        end
        g = (req_ready[1] === 1'b1) ? 1 : 0;
        sum = {1'b0, req_a[8*g +: 8]} + {1'b0, req_b[8*g +: 8]} + {8'b0, req_ci[g]};
        exp_q.push_back({1'b1, g[0], sum});
        @(posedge clk); #1;
        req_a[8*g +: 8] = 8'($urandom);
        req_b[8*g +: 8] = 8'($urandom);
        grants++;
      end
    end
    total++;
    if (grants != 4) begin bad++; $display("[TB] FAIL contention_count: got %0d grants expected 4", grants); end
    req_valid = 2'b00;
    drain();
  endtask

  task automatic test_chain();
    bit seen_other;
    bit got;
    issue(0, 8'h12, 8'h34, 1'b0, 1'b1);
    drain();
    @(posedge clk); #1;
    req_a[7:0] = 8'h11; req_b[7:0] = 8'h22; req_ci[0] = 1'b0; req_last[0] = 1'b1;
    req_a[15:8] = 8'hFF; req_b[15:8] = 8'h01; req_ci[1] = 1'b0; req_last[1] = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL chain_first_grant: got %b expected 10", req_ready); end
    exp_q.push_back({1'b0, 1'b1, 9'h100});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    seen_other = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready !== 2'b00) seen_other = 1;
    end
    total++;
    if (seen_other) begin bad++; $display("[TB] FAIL chain_starve: got a ready pulse, expected none while locked"); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL chain_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    req_a[15:8] = 8'h00; req_b[15:8] = 8'h00; req_ci[1] = 1'b0; req_last[1] = 1'b1;
    req_valid[1] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL chain_second_grant: got %b expected 10", req_ready); end
    exp_q.push_back({1'b1, 1'b1, 9'h001});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) got = 1;
    end
    total++;
    if (!got || req_ready !== 2'b01) begin
      bad++; $display("[TB] FAIL chain_after_grant: got %b expected 01", req_ready);
    end
    if (got) begin
      exp_q.push_back({1'b1, 1'b0, 9'h033});
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    drain();
  endtask

  task automatic test_backpressure();
    bit         got;
    bit         unstable;
    bit         pulsed;
    logic [9:0] snap;
    issue(1, 8'hA5, 8'h5A, 1'b1, 1'b1);
    rsp_ready = 1'b0;
    req_a[7:0] = 8'h01; req_b[7:0] = 8'h02; req_ci[0] = 1'b0; req_last[0] = 1'b1;
    req_valid[0] = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1;
    end
    snap = {rsp_id, rsp_co, rsp_s};
    unstable = 0;
    pulsed = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_co, rsp_s} !== snap) unstable = 1;
      if (req_ready !== 2'b00) pulsed = 1;
    end
    total++;
    if (!got || unstable) begin
      bad++; $display("[TB] FAIL bp_stable: got valid=%b rsp=%h expected held rsp=%h", rsp_valid, {rsp_id, rsp_co, rsp_s}, snap);
    end
    total++;
    if (pulsed) begin bad++; $display("[TB] FAIL bp_no_ready: got a ready pulse, expected none"); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    bit got;
    issue(1, 8'h80, 8'h80, 1'b0, 1'b0);
    drain();
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_lock_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    req_a[15:8] = 8'h01; req_b[15:8] = 8'h01; req_ci[1] = 1'b0; req_last[1] = 1'b1;
    req_valid[1] = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL mid_grant: got %b expected 10", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    req_a[7:0] = 8'h05; req_b[7:0] = 8'h06; req_ci[0] = 1'b1; req_last[0] = 1'b1;
    req_valid[0] = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, busy} !== 4'b0000) begin
      bad++; $display("[TB] FAIL mid_reset_ctrl: got ready=%b valid=%b busy=%b expected all 0", req_ready, rsp_valid, busy);
    end
    total++;
    if ({rsp_id, rsp_co, rsp_s, toggle_cnt} !== 26'h0) begin
      bad++; $display("[TB] FAIL mid_reset_data: got %h expected 0", {rsp_id, rsp_co, rsp_s, toggle_cnt});
    end
    exp_q.delete();
    m_lock = 1'b0;
    m_c    = 1'b0;
    m_rr   = 0;
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    got = (req_ready === 2'b01);
    total++;
    if (!got) begin bad++; $display("[TB] FAIL mid_lock_cleared: got %b expected 01", req_ready); end
    if (got) begin
      exp_q.push_back({1'b1, 1'b0, 9'h00C});
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    drain();
  endtask

  task automatic test_toggle();
    apply_reset();
    issue(0, 8'h00, 8'h00, 1'b0, 1'b1);
    drain();
    total++;
    if (toggle_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL toggle_first: got %h expected 0000", toggle_cnt); end
    issue(1, 8'hFF, 8'h00, 1'b0, 1'b1);
    drain();
    total++;
    if (toggle_cnt !== EXP_TOG) begin bad++; $display("[TB] FAIL toggle_second: got %h expected %h", toggle_cnt, EXP_TOG); end
  endtask

  initial begin
    reset_L   = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_ci    = '0;
    req_last  = '0;
    rsp_ready = 1'b1;
    m_lock    = 1'b0;
    m_c       = 1'b0;
    m_rr      = 0;
    test_reset();
    test_single();
    test_overflow();
    test_random();
    test_contention();
    test_chain();
    test_backpressure();
    test_reset_mid();
    test_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
